// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one synchronous FIFO write port
// among NUM_REQ producers. Each grant issues one registered write. Issue is
// throttled on full/almostfull so the FIFO never overflows from this block's
// writes. The producer that owned each write is acknowledged when the FIFO
// returns wr_ack, one cycle after the write edge.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic                            fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]           fifo_data_in,
  input  logic                            fifo_full,
  input  logic                            fifo_almostfull,
  input  logic                            fifo_wr_ack,
  input  logic                            fifo_overflow,
  output logic                            ovf_err,
  output logic [$clog2(NUM_REQ)-1:0]      ovf_src
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Registered state
  logic [NUM_REQ-1:0]    gnt_q,     gnt_d;
  logic [NUM_REQ-1:0]    own_q,     own_d;      // owner of the write in flight
  logic                  wr_en_q,   wr_en_d;
  logic [FIFO_WIDTH-1:0] data_q,    data_d;
  logic [IDX_W-1:0]      ptr_q,     ptr_d;      // round-robin search start
  logic                  ovf_err_q, ovf_err_d;
  logic [IDX_W-1:0]      ovf_src_q, ovf_src_d;

  // Arbitration intermediates
  logic [NUM_REQ-1:0]    elig;
  logic                  found;
  logic                  issue;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W-1:0]      own_idx;
  int                    idx;

  // Round-robin search over producers not granted in the current cycle, plus throttling.
  // NOTE: every variable written here gets a default before any conditional
  // assignment, so no path leaves a value held and no latch is inferred.
  always_comb begin
    elig   = req & ~gnt_q;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
    // A write in flight lands at the next edge, so almostfull then means full.
    issue = found && !fifo_full && !(wr_en_q && fifo_almostfull);
  end

  // Encode the one-hot owner register into a producer index for error capture.
  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (own_q[i]) own_idx = IDX_W'(i);
    end
  end

  // Next-state for grant, write port, pointer, owner tracking and sticky error.
  always_comb begin
    gnt_d     = '0;
    wr_en_d   = 1'b0;
    data_d    = data_q;
    ptr_d     = ptr_q;
    own_d     = gnt_q;
    ovf_err_d = ovf_err_q;
    ovf_src_d = ovf_src_q;
    if (issue) begin
      gnt_d[winner] = 1'b1;
      wr_en_d       = 1'b1;
      data_d        = req_data[int'(winner)*FIFO_WIDTH +: FIFO_WIDTH];
      ptr_d         = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
    // Only the first overflow is recorded; later ones keep the original source.
    if (fifo_overflow && (|own_q) && !ovf_err_q) begin
      ovf_err_d = 1'b1;
      ovf_src_d = own_idx;
    end
  end

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order or process scheduling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      own_q     <= '0;
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      ptr_q     <= '0;
      ovf_err_q <= 1'b0;
      ovf_src_q <= '0;
    end else begin
      gnt_q     <= gnt_d;
      own_q     <= own_d;
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
      ptr_q     <= ptr_d;
      ovf_err_q <= ovf_err_d;
      ovf_src_q <= ovf_src_d;
    end
  end

  assign gnt          = gnt_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_data_in = data_q;
  assign ovf_err      = ovf_err_q;
  assign ovf_src      = ovf_src_q;
  // The ack is the only combinational output: owner of last edge's write gated by wr_ack.
  assign req_ack      = own_q & {NUM_REQ{fifo_wr_ack}};

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: behavioural FIFO (depth 8), contract-following
// producers, and a scoreboard of expected writes compared as the DUT issues them.
module tb_fifo_wr_arbiter;

  localparam int NR    = 4;
  localparam int W     = 16;
  localparam int DEPTH = 8;

  typedef struct {
    logic [NR-1:0] g;
    logic [W-1:0]  d;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   req_ack;
  logic            fifo_wr_en;
  logic [W-1:0]    fifo_data_in;
  logic            fifo_full;
  logic            fifo_almostfull;
  logic            fifo_wr_ack;
  logic            fifo_overflow;
  logic            ovf_err;
  logic [1:0]      ovf_src;

  // FIFO model state
  logic [W-1:0] fifo_mem [$];
  int           m_cnt;
  logic         m_wr_ack;
  logic         m_ovf;
  logic         wacc;
  logic         racc;
  logic         rd_en;
  logic         force_ovf;

  // Producers and scoreboard
  logic [W-1:0]  words [NR][8];
  int            wcnt [NR];
  int            wpos [NR];
  exp_t          exp_q [$];
  logic [NR-1:0] ack_exp;
  int            n_checks = 0;
  int            n_fail   = 0;

  fifo_wr_arbiter #(.NUM_REQ(NR), .FIFO_WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .req_data        (req_data),
    .gnt             (gnt),
    .req_ack         (req_ack),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_data_in    (fifo_data_in),
    .fifo_full       (fifo_full),
    .fifo_almostfull (fifo_almostfull),
    .fifo_wr_ack     (fifo_wr_ack),
    .fifo_overflow   (fifo_overflow),
    .ovf_err         (ovf_err),
    .ovf_src         (ovf_src)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous FIFO: write accepted when not full, ack/overflow one cycle later.
  assign wacc            = fifo_wr_en && (m_cnt < DEPTH);
  assign racc            = rd_en && (m_cnt > 0);
  assign fifo_full       = (m_cnt == DEPTH);
  assign fifo_almostfull = (m_cnt == DEPTH - 1);
  assign fifo_wr_ack     = m_wr_ack;
  assign fifo_overflow   = m_ovf | force_ovf;

  always @(posedge clk) begin
    if (!rst_n) begin
      fifo_mem.delete();
      m_cnt    <= 0;
      m_wr_ack <= 1'b0;
      m_ovf    <= 1'b0;
    end else begin
      if (racc) void'(fifo_mem.pop_front());
      if (wacc) fifo_mem.push_back(fifo_data_in);
      m_cnt    <= m_cnt + int'(wacc) - int'(racc);
      m_wr_ack <= wacc;
      m_ovf    <= fifo_wr_en && !wacc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (wpos[i] < wcnt[i]) begin
        req[i]            = 1'b1;
        req_data[i*W +: W] = words[i][wpos[i]];
      end else begin
        req[i]            = 1'b0;
        req_data[i*W +: W] = '0;
      end
    end
  endtask

  task automatic load(input int i, input int n, input logic [W-1:0] base);
    wcnt[i] = n;
    wpos[i] = 0;
    for (int k = 0; k < n; k++) words[i][k] = base + W'(k);
    drive();
  endtask

  task automatic expect_wr(input int i, input int k);
    exp_t e;
    e.g    = '0;
    e.g[i] = 1'b1;
    e.d    = words[i][k];
    exp_q.push_back(e);
  endtask

  // Per-cycle scoreboard: ack from the previous write, issued write vs expected, no real overflow.
  task automatic monitor();
    exp_t e;
    check("req_ack", req_ack, ack_exp);
    ack_exp = '0;
    check("fifo_overflow_model", m_ovf, 1'b0);
    if (fifo_wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr", fifo_wr_en, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("gnt", gnt, e.g);
        check("fifo_data_in", fifo_data_in, e.d);
        ack_exp = e.g;
      end
    end else begin
      check("idle_gnt", gnt, '0);
    end
  endtask

  // One clock: sample #1 after the edge, then producers consume granted words.
  task automatic cycle();
    @(posedge clk);
    #1;
    monitor();
    for (int i = 0; i < NR; i++) begin
      if (gnt[i] && wpos[i] < wcnt[i]) wpos[i]++;
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    rd_en     = 1'b0;
    force_ovf = 1'b0;
    for (int i = 0; i < NR; i++) begin
      wcnt[i] = 0;
      wpos[i] = 0;
    end
    drive();
    exp_q.delete();
    ack_exp = '0;
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:4] t1_pat;
    logic [W-1:0] cont_words [$];

    ack_exp = '0;
    do_reset();
    check("rst_gnt", gnt, '0);
    check("rst_wr_en", fifo_wr_en, 1'b0);
    check("rst_data", fifo_data_in, '0);
    check("rst_ovf_err", ovf_err, 1'b0);
    check("rst_ovf_src", ovf_src, '0);
    check("rst_req_ack", req_ack, '0);

    // Single producer 2: 1-cycle grant latency, re-grant every other cycle.
    load(2, 3, 16'hA5A5);
    for (int k = 0; k < 3; k++) expect_wr(2, k);
    cycle();
    check("t1_gnt", gnt, 4'b0100);
    check("t1_data", fifo_data_in, 16'hA5A5);
    t1_pat = 5'b01010;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("t1_wr_pattern", fifo_wr_en, t1_pat[c]);
    end
    run(3);
    check("t1_drain", exp_q.size(), 0);

    // Contention: all four from reset, back-to-back rotating grants.
    do_reset();
    for (int i = 0; i < NR; i++) load(i, 2, W'((i + 1) * 16'h1000));
    cont_words.delete();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) begin
        expect_wr(i, k);
        cont_words.push_back(words[i][k]);
      end
    end
    run(12);
    check("cont_drain", exp_q.size(), 0);
    check("cont_fifo_level", fifo_mem.size(), 8);
    for (int k = 0; k < 8 && k < fifo_mem.size(); k++) check("cont_fifo_order", fifo_mem[k], cont_words[k]);

    // Fairness: leave ptr at 2 via one grant to producer 1, then req=1011.
    do_reset();
    load(1, 1, 16'h3100);
    expect_wr(1, 0);
    run(3);
    load(0, 2, 16'h3000);
    load(1, 2, 16'h3110);
    load(3, 2, 16'h3300);
    for (int k = 0; k < 2; k++) begin
      expect_wr(3, k);
      expect_wr(0, k);
      expect_wr(1, k);
    end
    run(10);
    check("fair_drain", exp_q.size(), 0);

    // Backpressure: no reads, exactly 8 writes fill the FIFO, then one read frees one slot.
    do_reset();
    for (int i = 0; i < NR; i++) load(i, 4, W'((i + 1) * 16'h0100));
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) expect_wr(i, k);
    end
    run(20);
    check("bp_drain", exp_q.size(), 0);
    check("bp_level", m_cnt, DEPTH);
    check("bp_stalled", fifo_wr_en, 1'b0);
    expect_wr(0, 2);
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    run(10);
    check("bp_one_more_drain", exp_q.size(), 0);
    check("bp_level_after_read", m_cnt, DEPTH);

    // Forced overflow on producer 1's write; later overflow on producer 3 keeps the source.
    do_reset();
    load(1, 1, 16'h4100);
    expect_wr(1, 0);
    cycle();
    cycle();
    force_ovf = 1'b1;
    cycle();
    force_ovf = 1'b0;
    check("ovf_err_set", ovf_err, 1'b1);
    check("ovf_src_1", ovf_src, 2'd1);
    load(3, 1, 16'h4300);
    expect_wr(3, 0);
    cycle();
    cycle();
    force_ovf = 1'b1;
    cycle();
    force_ovf = 1'b0;
    run(3);
    check("ovf_err_sticky", ovf_err, 1'b1);
    check("ovf_src_first", ovf_src, 2'd1);
    do_reset();
    check("ovf_err_cleared", ovf_err, 1'b0);
    check("ovf_src_cleared", ovf_src, '0);

    // Reset mid-stream while gnt=1000: outputs clear, no stale ack, restart from ptr 0.
    do_reset();
    for (int i = 0; i < NR; i++) load(i, 2, W'((i + 5) * 16'h1000));
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) expect_wr(i, k);
    end
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (gnt == 4'b1000) break;
    end
    check("rm_find_gnt3", gnt, 4'b1000);
    rst_n = 1'b0;
    exp_q.delete();
    ack_exp = '0;
    for (int i = 0; i < NR; i++) begin
      wcnt[i] = 0;
      wpos[i] = 0;
    end
    drive();
    cycle();
    check("rm_gnt", gnt, '0);
    check("rm_wr_en", fifo_wr_en, 1'b0);
    check("rm_data", fifo_data_in, '0);
    check("rm_req_ack", req_ack, '0);
    check("rm_ovf_err", ovf_err, 1'b0);
    check("rm_ovf_src", ovf_src, '0);
    rst_n = 1'b1;
    load(1, 1, 16'h7100);
    load(3, 1, 16'h7300);
    expect_wr(1, 0);
    expect_wr(3, 0);
    cycle();
    check("rm_first_gnt", gnt, 4'b0010);
    run(6);
    check("rm_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
